// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle of the prefetch queue: ROM request/ack channel plus the IT-stage drain,
// stall and redirect controls.
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_ack_i;
    logic [DATA_W-1:0] rom_data_i;
    logic              stall_i;
    logic              flush_i;
    logic [ADDR_W-1:0] new_pc_i;
    logic              br_flag_i;
    logic [ADDR_W-1:0] br_tat_add_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        input  rom_ack_i, rom_data_i, stall_i, flush_i, new_pc_i, br_flag_i, br_tat_add_i
    );

    modport slave (
        input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        output rom_ack_i, rom_data_i, stall_i, flush_i, new_pc_i, br_flag_i, br_tat_add_i
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-entry {pc, inst} FIFO fed by a single-outstanding ROM fetch,
// with exception flush and delay-slot-preserving branch redirect.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    if_prefetch_queue_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

    state_t            state_r, state_n;
    logic [ADDR_W-1:0] fpc_r, fpc_n;
    logic [ADDR_W-1:0] rom_addr_r, addr_n;
    logic              rom_req_r, req_n;
    logic              redir_r, redir_n;
    logic [ADDR_W-1:0] redir_pc_r, redir_pc_n;
    logic [PW-1:0]     rd_ptr_r, rd_n, wr_ptr_r, wr_n;
    logic [CW-1:0]     count_r, cnt_n;
    logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
    logic [DATA_W-1:0] mem_inst_r [DEPTH];

    logic              valid_s, pop_s, push_s, trim_s, ack_s;
    logic [CW-1:0]     cnt_pop_s;
    logic [PW-1:0]     rd_pop_s;

    assign valid_s   = (count_r != CW'(1'b0));
    assign pop_s     = valid_s && !bus.stall_i;
    assign cnt_pop_s = count_r - CW'(pop_s);
    assign rd_pop_s  = rd_ptr_r + PW'(pop_s);
    assign ack_s     = bus.rom_ack_i;
    // A branch that still leaves an entry behind keeps only that head as the delay slot.
    assign trim_s    = bus.br_flag_i && (cnt_pop_s != CW'(1'b0));

    assign bus.rom_req_o    = rom_req_r;
    assign bus.rom_addr_o   = rom_addr_r;
    assign bus.inst_valid_o = valid_s;
    assign bus.inst_o       = valid_s ? mem_inst_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign bus.inst_pc_o    = valid_s ? mem_pc_r[rd_ptr_r]   : {ADDR_W{1'b0}};
    assign bus.count_o      = count_r;

    // Next-state, fetch-pointer and queue-pointer logic.
    always_comb begin
        state_n    = state_r;
        fpc_n      = fpc_r;
        addr_n     = rom_addr_r;
        req_n      = rom_req_r;
        redir_n    = redir_r;
        redir_pc_n = redir_pc_r;
        rd_n       = rd_pop_s;
        wr_n       = wr_ptr_r;
        cnt_n      = cnt_pop_s;
        push_s     = 1'b0;
        if (bus.flush_i) begin
            cnt_n   = CW'(1'b0);
            rd_n    = PW'(1'b0);
            wr_n    = PW'(1'b0);
            fpc_n   = bus.new_pc_i;
            redir_n = 1'b0;
            case (state_r)
                REQ, DROP: begin
                    if (ack_s) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else begin
                        state_n = DROP;
                    end
                end
                IDLE:    state_n = IDLE;
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (trim_s) begin
                        cnt_n   = CW'(1'b1);
                        wr_n    = rd_pop_s + PW'(1'b1);
                        fpc_n   = bus.br_tat_add_i;
                        redir_n = 1'b0;
                    end else begin
                        if (bus.br_flag_i) begin
                            redir_n    = 1'b1;
                            redir_pc_n = bus.br_tat_add_i;
                        end else begin
                            redir_n = redir_r;
                        end
                        if (count_r < CW'(DEPTH)) begin
                            state_n = REQ;
                            req_n   = 1'b1;
                            addr_n  = fpc_r;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                REQ: begin
                    if (trim_s) begin
                        cnt_n   = CW'(1'b1);
                        wr_n    = rd_pop_s + PW'(1'b1);
                        fpc_n   = bus.br_tat_add_i;
                        redir_n = 1'b0;
                        if (ack_s) begin
                            state_n = IDLE;
                            req_n   = 1'b0;
                        end else begin
                            state_n = DROP;
                        end
                    end else if (ack_s) begin
                        push_s  = 1'b1;
                        wr_n    = wr_ptr_r + PW'(1'b1);
                        cnt_n   = cnt_pop_s + CW'(1'b1);
                        state_n = IDLE;
                        req_n   = 1'b0;
                        redir_n = 1'b0;
                        if (bus.br_flag_i) begin
                            fpc_n = bus.br_tat_add_i;
                        end else if (redir_r) begin
                            fpc_n = redir_pc_r;
                        end else begin
                            fpc_n = fpc_r + ADDR_W'(3'd4);
                        end
                    end else if (bus.br_flag_i) begin
                        // In-flight fetch is the delay slot; jump once it lands.
                        redir_n    = 1'b1;
                        redir_pc_n = bus.br_tat_add_i;
                    end else begin
                        state_n = REQ;
                    end
                end
                DROP: begin
                    if (trim_s) begin
                        cnt_n   = CW'(1'b1);
                        wr_n    = rd_pop_s + PW'(1'b1);
                        fpc_n   = bus.br_tat_add_i;
                        redir_n = 1'b0;
                    end else if (bus.br_flag_i) begin
                        redir_n    = 1'b1;
                        redir_pc_n = bus.br_tat_add_i;
                    end else begin
                        redir_n = redir_r;
                    end
                    if (ack_s) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else begin
                        state_n = DROP;
                    end
                end
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            fpc_r      <= RESET_PC;
            rom_addr_r <= {ADDR_W{1'b0}};
            rom_req_r  <= 1'b0;
            redir_r    <= 1'b0;
            redir_pc_r <= {ADDR_W{1'b0}};
            rd_ptr_r   <= PW'(1'b0);
            wr_ptr_r   <= PW'(1'b0);
            count_r    <= CW'(1'b0);
        end else begin
            state_r    <= state_n;
            fpc_r      <= fpc_n;
            rom_addr_r <= addr_n;
            rom_req_r  <= req_n;
            redir_r    <= redir_n;
            redir_pc_r <= redir_pc_n;
            rd_ptr_r   <= rd_n;
            wr_ptr_r   <= wr_n;
            count_r    <= cnt_n;
        end
    end

    // Queue storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= fpc_r;
            mem_inst_r[wr_ptr_r] <= bus.rom_data_i;
        end else begin
            mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
            mem_inst_r[wr_ptr_r] <= mem_inst_r[wr_ptr_r];
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: ROM model with programmable latency, pop log of the
// IT-side drain, and hand-computed expectations for each scenario.
module tb_if_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();

    if_prefetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    int          wait_cnt = 0;
    logic        rom_en  = 1'b1;
    logic        model_ack = 1'b0;
    logic        man_ack   = 1'b0;
    logic [31:0] model_data = 32'h0;
    logic [31:0] pc_log[$];
    logic [31:0] inst_log[$];
    logic [2:0]  cmax = 3'd0;

    assign bus.rom_ack_i  = model_ack | man_ack;
    assign bus.rom_data_i = model_data;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        pc_log.delete();
        inst_log.delete();
    endtask

    task automatic wait_pops(input int n, input int max_cyc);
        int k = 0;
        while (pc_log.size() < n && k < max_cyc) begin
            tick();
            k++;
        end
        check_eq("pop_budget", 32'(pc_log.size() >= n), 32'd1);
    endtask

    task automatic wait_req(input logic [31:0] addr, input logic any_addr, input int max_cyc);
        int k = 0;
        while (!(bus.rom_req_o && (any_addr || bus.rom_addr_o == addr)) && k < max_cyc) begin
            tick();
            k++;
        end
        check_eq("req_budget", 32'(k < max_cyc), 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        bus.flush_i  = 1'b1;
        bus.new_pc_i = pc;
        tick();
        bus.flush_i  = 1'b0;
        clear_log();
    endtask

    // ROM model: acks a held request after lat idle cycles, one cycle wide.
    always @(negedge clk) begin
        if (model_ack) begin
            model_ack = 1'b0;
            wait_cnt  = 0;
        end else if (rom_en && bus.rom_req_o) begin
            if (wait_cnt >= lat) begin
                model_ack  = 1'b1;
                model_data = rom_word(bus.rom_addr_o);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Pop monitor: a pop completes at the next edge when the head is valid and not stalled.
    always @(negedge clk) begin
        if (rst && bus.inst_valid_o && !bus.stall_i) begin
            pc_log.push_back(bus.inst_pc_o);
            inst_log.push_back(bus.inst_o);
        end
        if (bus.count_o > cmax) cmax = bus.count_o;
    end

    initial begin
        bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.new_pc_i = 32'h0;
        bus.br_flag_i = 1'b0; bus.br_tat_add_i = 32'h0;

        // 1: reset values, then sequential fetch at latency 1
        repeat (3) tick();
        check_eq("rst_req",   32'(bus.rom_req_o),    32'd0);
        check_eq("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check_eq("rst_count", 32'(bus.count_o),      32'd0);
        check_eq("rst_inst",  bus.inst_o,            32'h0);
        check_eq("rst_pc",    bus.inst_pc_o,         32'h0);
        rst = 1'b1; cmax = 3'd0; clear_log();
        tick();
        check_eq("first_addr", bus.rom_addr_o, 32'h0);
        check_eq("first_req",  32'(bus.rom_req_o), 32'd1);
        wait_pops(4, 100);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_pc",   pc_log[i],   32'(4 * i));
            check_eq("t1_inst", inst_log[i], rom_word(32'(4 * i)));
        end
        check_eq("t1_cmax", 32'(cmax), 32'd1);

        // 2: stall held at latency 0 fills the queue, then drains in order
        rst = 1'b0; bus.stall_i = 1'b1; lat = 0;
        tick();
        rst = 1'b1;
        repeat (20) tick();
        check_eq("t2_count", 32'(bus.count_o),   32'd4);
        check_eq("t2_req",   32'(bus.rom_req_o), 32'd0);
        check_eq("t2_head",  bus.inst_pc_o,      32'h0);
        clear_log();
        bus.stall_i = 1'b0;
        wait_pops(4, 50);
        for (int i = 0; i < 4; i++) check_eq("t2_pc", pc_log[i], 32'(4 * i));

        // 3: branch on pop of 0x100 keeps 0x104 as delay slot, drops 0x108
        bus.stall_i = 1'b1;
        do_flush(32'h100);
        begin
            int k = 0;
            while (bus.count_o != 3'd3 && k < 50) begin tick(); k++; end
            check_eq("t3_fill", 32'(bus.count_o), 32'd3);
        end
        check_eq("t3_head", bus.inst_pc_o, 32'h100);
        bus.stall_i = 1'b0; bus.br_flag_i = 1'b1; bus.br_tat_add_i = 32'h200;
        tick();
        bus.br_flag_i = 1'b0;
        check_eq("t3_trim_cnt", 32'(bus.count_o), 32'd1);
        check_eq("t3_trim_pc",  bus.inst_pc_o,    32'h104);
        wait_pops(3, 50);
        check_eq("t3_p0", pc_log[0], 32'h100);
        check_eq("t3_p1", pc_log[1], 32'h104);
        check_eq("t3_p2", pc_log[2], 32'h200);
        check_eq("t3_i2", inst_log[2], rom_word(32'h200));

        // 4: empty queue, fetch 0x40 outstanding, branch to 0x80
        lat = 5;
        do_flush(32'h40);
        wait_req(32'h40, 1'b0, 60);
        check_eq("t4_empty", 32'(bus.count_o), 32'd0);
        bus.br_flag_i = 1'b1; bus.br_tat_add_i = 32'h80;
        tick();
        bus.br_flag_i = 1'b0;
        check_eq("t4_addr_hold", bus.rom_addr_o, 32'h40);
        wait_pops(2, 60);
        check_eq("t4_p0", pc_log[0], 32'h40);
        check_eq("t4_p1", pc_log[1], 32'h80);

        // 5: flush beats same-cycle branch; in-flight 0x20 data discarded
        do_flush(32'h20);
        wait_req(32'h20, 1'b0, 60);
        bus.flush_i = 1'b1; bus.new_pc_i = 32'h180;
        bus.br_flag_i = 1'b1; bus.br_tat_add_i = 32'h300;
        tick();
        bus.flush_i = 1'b0; bus.br_flag_i = 1'b0;
        clear_log();
        check_eq("t5_drop_req",  32'(bus.rom_req_o), 32'd1);
        check_eq("t5_drop_addr", bus.rom_addr_o,     32'h20);
        check_eq("t5_drop_cnt",  32'(bus.count_o),   32'd0);
        wait_pops(2, 100);
        check_eq("t5_p0", pc_log[0],   32'h180);
        check_eq("t5_i0", inst_log[0], rom_word(32'h180));
        check_eq("t5_p1", pc_log[1],   32'h184);

        // 6: address wrap, then reset mid-request and a late ack
        lat = 0;
        do_flush(32'hFFFF_FFFC);
        wait_pops(2, 60);
        check_eq("t6_wrap0", pc_log[0], 32'hFFFF_FFFC);
        check_eq("t6_wrap1", pc_log[1], 32'h0000_0000);
        lat = 5;
        wait_req(32'h0, 1'b1, 30);
        rst = 1'b0; rom_en = 1'b0;
        #1;
        check_eq("t6_rst_req",   32'(bus.rom_req_o),    32'd0);
        check_eq("t6_rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check_eq("t6_rst_count", 32'(bus.count_o),      32'd0);
        check_eq("t6_rst_pc",    bus.inst_pc_o,         32'h0);
        tick();
        rst = 1'b1; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check_eq("t6_late_cnt",  32'(bus.count_o),   32'd0);
        check_eq("t6_late_req",  32'(bus.rom_req_o), 32'd1);
        check_eq("t6_late_addr", bus.rom_addr_o,     32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
